monster_state_updater: RTL and testbench

Sequential owner of the twelve packed monster state words consumed by the sprite renderer. Once per frame tick it walks all slots, one per clock, advancing live monsters by one step in their heading and reversing heading at playfield edges. It also services spawn requests into the lowest free slot and kill commands from the hit logic. It drives m0..m11 directly into the monster render path.

---
 rtl/monster_state_updater.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_monster_state_updater.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monster_state_updater.sv
`default_nettype none
// ============================================================================
// Module      : monster_state_updater
// Description : Owns the twelve packed monster state words read by the sprite
//               renderer. On each frame tick it walks every slot, one per
//               clock, stepping live monsters along their heading and
//               reversing heading at the playfield edges. Between scans it
//               accepts spawn requests into the lowest free slot. Kill
//               commands are honoured in every state.
//
// Ports       : clk, rst         - clock, synchronous active-high reset
//               tick             - frame tick (one-cycle pulse)
//               spawn_valid/_ready, spawn_x/_y/_dir - spawn handshake
//               spawn_full       - pulse: accepted spawn found no free slot
//               kill, kill_idx   - clear alive bit of a slot (idx >= 12 ignored)
//               m0..m11          - state words {y[18:11], x[10:3], dir[2:1], alive[0]}
//                                  dir: 00 up, 01 down, 10 left, 11 right
//               busy             - high while scanning
//               done             - one-cycle pulse after the scan
//               overrun          - sticky: tick seen while not idle
//
// Option      : define MONSTER_RANDOM_TURN_EN to add an 8-bit LFSR that
//               randomly re-heads live monsters during the scan.
//
// Revision    : 1.0 - initial release
// ============================================================================
module monster_state_updater #(
    parameter int MONS_W = 20,
    parameter int MONS_H = 21,
    parameter int X_MAX  = 160,
    parameter int Y_MAX  = 120,
    parameter int STEP   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        spawn_valid,
    output logic        spawn_ready,
    input  logic [7:0]  spawn_x,
    input  logic [7:0]  spawn_y,
    input  logic [1:0]  spawn_dir,
    output logic        spawn_full,
    input  logic        kill,
    input  logic [3:0]  kill_idx,
    output logic [18:0] m0,
    output logic [18:0] m1,
    output logic [18:0] m2,
    output logic [18:0] m3,
    output logic [18:0] m4,
    output logic [18:0] m5,
    output logic [18:0] m6,
    output logic [18:0] m7,
    output logic [18:0] m8,
    output logic [18:0] m9,
    output logic [18:0] m10,
    output logic [18:0] m11,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam int MONSTERS = 12;

    // Boundary arithmetic is done at 9 bits so x/y + STEP + sprite size
    // cannot wrap.
    localparam logic [8:0] c_STEP9   = 9'(STEP);
    localparam logic [8:0] c_MONS_W9 = 9'(MONS_W);
    localparam logic [8:0] c_MONS_H9 = 9'(MONS_H);
    localparam logic [8:0] c_X_MAX9  = 9'(X_MAX);
    localparam logic [8:0] c_Y_MAX9  = 9'(Y_MAX);

    // Largest legal top-left corner; spawn coordinates are clamped to it.
    localparam logic [7:0] c_X_LIM   = 8'(X_MAX - MONS_W);
    localparam logic [7:0] c_Y_LIM   = 8'(Y_MAX - MONS_H);
    localparam logic [3:0] c_LAST    = 4'(MONSTERS - 1);

    localparam logic [1:0] c_DIR_UP    = 2'b00;
    localparam logic [1:0] c_DIR_DOWN  = 2'b01;
    localparam logic [1:0] c_DIR_LEFT  = 2'b10;
    localparam logic [1:0] c_DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic        r_spawn_full;
    logic        r_overrun;
    logic [18:0] r_mon     [MONSTERS];
    logic [18:0] w_mon_nxt [MONSTERS];

    logic        w_spawn_fire;
    logic        w_free_found;
    logic [3:0]  w_free_idx;
    logic [18:0] w_spawn_word;
    logic [7:0]  w_spawn_x_cl;
    logic [7:0]  w_spawn_y_cl;

    logic [7:0]  w_cur_x;
    logic [7:0]  w_cur_y;
    logic [1:0]  w_cur_dir;
    logic [1:0]  w_head;
    logic [8:0]  w_x9;
    logic [8:0]  w_y9;
    logic [8:0]  w_nx9;
    logic [8:0]  w_ny9;
    logic        w_blocked;
    logic [18:0] w_moved;

    // ------------------------------------------------------------------
    // Optional random-turn LFSR (x^8 + x^6 + x^5 + x^4 + 1)
    // ------------------------------------------------------------------
`ifdef MONSTER_RANDOM_TURN_EN
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // The random heading replaces the stored one before the edge test, so a
    // turn into a wall is immediately reversed by the boundary rule.
    assign w_head = (r_lfsr[2:0] == 3'b000) ? r_lfsr[4:3] : w_cur_dir;
`else
    assign w_head = w_cur_dir;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (tick) w_state_nxt = S_SCAN;
            S_SCAN:  if (r_idx == c_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tick has priority: a spawn presented with a tick waits for the scan.
    assign spawn_ready  = (r_state == S_IDLE) & ~tick;
    assign w_spawn_fire = spawn_valid & spawn_ready;

    // ------------------------------------------------------------------
    // Spawn: lowest free slot and clamped coordinates
    // ------------------------------------------------------------------
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = 4'd0;
        // Descending walk so the lowest free index is the one left standing.
        for (int i = MONSTERS - 1; i >= 0; i--) begin
            if (!r_mon[i][0]) begin
                w_free_found = 1'b1;
                w_free_idx   = 4'(i);
            end
        end
    end

    assign w_spawn_x_cl = (spawn_x > c_X_LIM) ? c_X_LIM : spawn_x;
    assign w_spawn_y_cl = (spawn_y > c_Y_LIM) ? c_Y_LIM : spawn_y;
    assign w_spawn_word = {w_spawn_y_cl, w_spawn_x_cl, spawn_dir, 1'b1};

    // ------------------------------------------------------------------
    // Movement of the slot under the scan pointer
    // ------------------------------------------------------------------
    assign w_cur_x   = r_mon[r_idx][10:3];
    assign w_cur_y   = r_mon[r_idx][18:11];
    assign w_cur_dir = r_mon[r_idx][2:1];
    assign w_x9      = {1'b0, w_cur_x};
    assign w_y9      = {1'b0, w_cur_y};

    always_comb begin
        w_blocked = 1'b0;
        w_nx9     = w_x9;
        w_ny9     = w_y9;
        case (w_head)
            c_DIR_UP: begin
                w_blocked = (w_y9 < c_STEP9);
                w_ny9     = w_y9 - c_STEP9;
            end
            c_DIR_DOWN: begin
                w_blocked = ((w_y9 + c_STEP9 + c_MONS_H9) > c_Y_MAX9);
                w_ny9     = w_y9 + c_STEP9;
            end
            c_DIR_LEFT: begin
                w_blocked = (w_x9 < c_STEP9);
                w_nx9     = w_x9 - c_STEP9;
            end
            c_DIR_RIGHT: begin
                w_blocked = ((w_x9 + c_STEP9 + c_MONS_W9) > c_X_MAX9);
                w_nx9     = w_x9 + c_STEP9;
            end
            default: begin
                w_blocked = 1'b0;
            end
        endcase

        // Blocked: flip the low heading bit (up<->down, left<->right), hold position.
        if (w_blocked) begin
            w_moved = {w_cur_y, w_cur_x, w_head ^ 2'b01, 1'b1};
        end else begin
            w_moved = {w_ny9[7:0], w_nx9[7:0], w_head, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Next value of every slot
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < MONSTERS; i++) begin
            w_mon_nxt[i] = r_mon[i];
            if (w_spawn_fire && w_free_found && (w_free_idx == 4'(i))) begin
                w_mon_nxt[i] = w_spawn_word;
            end
            if ((r_state == S_SCAN) && (r_idx == 4'(i)) && r_mon[i][0]) begin
                w_mon_nxt[i] = w_moved;
            end
            // Kill beats movement: the slot keeps its pre-scan x/y/dir.
            // A kill aimed at an already-dead slot is a no-op, so a spawn into
            // that slot in the same cycle is not lost.
            if (kill && (kill_idx == 4'(i)) && r_mon[i][0]) begin
                w_mon_nxt[i] = {r_mon[i][18:1], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= 4'd0;
            r_spawn_full <= 1'b0;
            r_overrun    <= 1'b0;
            for (int i = 0; i < MONSTERS; i++) begin
                r_mon[i] <= 19'h0;
            end
        end else begin
            r_spawn_full <= w_spawn_fire & ~w_free_found;
            if (tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if ((r_state == S_IDLE) && tick) begin
                r_idx <= 4'd0;
            end else if (r_state == S_SCAN) begin
                r_idx <= r_idx + 4'd1;
            end
            for (int i = 0; i < MONSTERS; i++) begin
                r_mon[i] <= w_mon_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy       = (r_state == S_SCAN);
    assign done       = (r_state == S_DONE);
    assign spawn_full = r_spawn_full;
    assign overrun    = r_overrun;

    assign m0  = r_mon[0];
    assign m1  = r_mon[1];
    assign m2  = r_mon[2];
    assign m3  = r_mon[3];
    assign m4  = r_mon[4];
    assign m5  = r_mon[5];
    assign m6  = r_mon[6];
    assign m7  = r_mon[7];
    assign m8  = r_mon[8];
    assign m9  = r_mon[9];
    assign m10 = r_mon[10];
    assign m11 = r_mon[11];

endmodule
`default_nettype wire

// File: tb/tb_monster_state_updater.sv
`default_nettype none
// ============================================================================
// Module      : tb_monster_state_updater
// Description : Directed self-checking bench for monster_state_updater.
//               Inputs change 1 ns after the rising edge; outputs are read
//               1-2 ns after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_monster_state_updater;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        spawn_valid = 1'b0;
    logic        spawn_ready;
    logic [7:0]  spawn_x = 8'd0;
    logic [7:0]  spawn_y = 8'd0;
    logic [1:0]  spawn_dir = 2'd0;
    logic        spawn_full;
    logic        kill = 1'b0;
    logic [3:0]  kill_idx = 4'd0;
    logic [18:0] m0, m1, m2, m3, m4, m5, m6, m7, m8, m9, m10, m11;
    logic        busy, done, overrun;

    logic [18:0] mon [12];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    monster_state_updater dut (
        .clk(clk), .rst(rst), .tick(tick),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir),
        .spawn_full(spawn_full), .kill(kill), .kill_idx(kill_idx),
        .m0(m0), .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5),
        .m6(m6), .m7(m7), .m8(m8), .m9(m9), .m10(m10), .m11(m11),
        .busy(busy), .done(done), .overrun(overrun)
    );

    assign mon[0] = m0;  assign mon[1] = m1;   assign mon[2]  = m2;
    assign mon[3] = m3;  assign mon[4] = m4;   assign mon[5]  = m5;
    assign mon[6] = m6;  assign mon[7] = m7;   assign mon[8]  = m8;
    assign mon[9] = m9;  assign mon[10] = m10; assign mon[11] = m11;

    // Advance n clock edges, ending 1 ns past the last one.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    // One-cycle tick; returns in cycle T+1 (first busy cycle).
    task automatic tick_pulse();
        tick = 1'b1;
        cycles(1);
        tick = 1'b0;
    endtask

    // Holds spawn_valid until accepted; returns in the cycle after the
    // accepting edge. waited = edges seen with spawn_ready low.
    task automatic do_spawn(input logic [7:0] x, input logic [7:0] y,
                            input logic [1:0] d, output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        spawn_x = x; spawn_y = y; spawn_dir = d; spawn_valid = 1'b1;
        for (int k = 0; k < 40 && !acc; k++) begin
            #1;
            acc = spawn_ready;
            @(posedge clk);
            #1;
            if (!acc) waited++;
        end
        spawn_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL spawn_timeout: spawn_ready seen=%0b, required 1 within 40 cycles", acc);
        end
    endtask

    task automatic test_reset();
        logic [18:0] zero;
        zero = 19'h0;
        do_reset();
        #1;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (mon[i] !== zero) begin
                n_fail++;
                $display("FAIL reset_m%0d: got %h, required %h", i, mon[i], zero);
            end
        end
        n_checks++;
        if ({busy, done, overrun, spawn_full, spawn_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/ovr/full/ready got %b, required 00001",
                     {busy, done, overrun, spawn_full, spawn_ready});
        end
    endtask

    task automatic test_spawn_and_move();
        int w;
        logic [18:0] exp;
        do_spawn(8'd10, 8'd10, 2'b11, w);
        exp = {8'd10, 8'd10, 2'b11, 1'b1};
        n_checks++;
        if (m0 !== exp) begin
            n_fail++; $display("FAIL spawn_m0: got %h, required %h", m0, exp);
        end
        tick_pulse();                                   // T+1
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || m0 !== exp) begin
            n_fail++;
            $display("FAIL tick_T1: busy=%b done=%b m0=%h, required busy=1 done=0 m0=%h",
                     busy, done, m0, exp);
        end
        cycles(1);                                      // T+2
        exp = {8'd10, 8'd11, 2'b11, 1'b1};
        n_checks++;
        if (m0 !== exp) begin
            n_fail++; $display("FAIL move_T2: m0 got %h, required %h", m0, exp);
        end
        cycles(11);                                     // T+13
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL done_T13: done=%b busy=%b, required 1 0", done, busy);
        end
        cycles(1);                                      // T+14
        n_checks++;
        if (done !== 1'b0 || spawn_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_T14: done=%b ready=%b, required 0 1", done, spawn_ready);
        end
    endtask

    task automatic test_bounce();
        int w;
        logic [18:0] exp;
        do_reset();
        do_spawn(8'd140, 8'd50, 2'b11, w);
        tick_pulse();
        cycles(13);
        exp = {8'd50, 8'd140, 2'b10, 1'b1};
        n_checks++;
        if (m0 !== exp) begin
            n_fail++; $display("FAIL bounce_turn: m0 got %h, required %h", m0, exp);
        end
        tick_pulse();
        cycles(13);
        exp = {8'd50, 8'd139, 2'b10, 1'b1};
        n_checks++;
        if (m0 !== exp) begin
            n_fail++; $display("FAIL bounce_step: m0 got %h, required %h", m0, exp);
        end
    endtask

    task automatic test_fill_and_clamp();
        int w;
        logic [18:0] exp [12];
        logic [18:0] e7;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            do_spawn(8'(i * 10), 8'd5, 2'b01, w);
            exp[i] = {8'd5, 8'(i * 10), 2'b01, 1'b1};
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (mon[i] !== exp[i]) begin
                n_fail++; $display("FAIL fill_m%0d: got %h, required %h", i, mon[i], exp[i]);
            end
        end
        do_spawn(8'd1, 8'd1, 2'b00, w);
        n_checks++;
        if (spawn_full !== 1'b1) begin
            n_fail++; $display("FAIL full_pulse: spawn_full got %b, required 1", spawn_full);
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (mon[i] !== exp[i]) begin
                n_fail++; $display("FAIL full_nochange_m%0d: got %h, required %h", i, mon[i], exp[i]);
            end
        end
        cycles(1);
        n_checks++;
        if (spawn_full !== 1'b0) begin
            n_fail++; $display("FAIL full_single: spawn_full got %b, required 0", spawn_full);
        end
        kill = 1'b1; kill_idx = 4'd7;
        cycles(1);
        kill = 1'b0;
        e7 = {8'd5, 8'd70, 2'b01, 1'b0};
        n_checks++;
        if (m7 !== e7) begin
            n_fail++; $display("FAIL kill_idle: m7 got %h, required %h", m7, e7);
        end
        do_spawn(8'd255, 8'd255, 2'b00, w);
        e7 = {8'd99, 8'd140, 2'b00, 1'b1};
        n_checks++;
        if (m7 !== e7) begin
            n_fail++; $display("FAIL clamp: m7 got %h, required %h", m7, e7);
        end
    endtask

    task automatic test_kill_during_scan();
        int w;
        logic [18:0] e5;
        logic [18:0] e4;
        do_reset();
        for (int i = 0; i < 6; i++) do_spawn(8'd20, 8'd20, 2'b11, w);
        tick_pulse();                                   // T+1
        cycles(5);                                      // T+6: slot 5 processed
        kill = 1'b1; kill_idx = 4'd5;
        cycles(1);                                      // T+7
        kill_idx = 4'd13;
        e5 = {8'd20, 8'd20, 2'b11, 1'b0};
        e4 = {8'd20, 8'd21, 2'b11, 1'b1};
        n_checks++;
        if (m5 !== e5) begin
            n_fail++; $display("FAIL kill_scan: m5 got %h, required %h", m5, e5);
        end
        n_checks++;
        if (m4 !== e4) begin
            n_fail++; $display("FAIL scan_m4: got %h, required %h", m4, e4);
        end
        cycles(1);                                      // T+8
        kill = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (mon[i] !== e4) begin
                n_fail++; $display("FAIL kill13_m%0d: got %h, required %h", i, mon[i], e4);
            end
        end
        cycles(6);                                      // T+14
        n_checks++;
        if (m5 !== e5) begin
            n_fail++; $display("FAIL kill_hold: m5 got %h, required %h", m5, e5);
        end
    endtask

    task automatic test_overrun_and_priority();
        int w;
        logic [18:0] e1;
        do_reset();
        do_spawn(8'd30, 8'd30, 2'b00, w);
        tick_pulse();                                   // T+1
        cycles(4);                                      // T+5
        tick_pulse();                                   // T+6
        n_checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL overrun_set: overrun=%b busy=%b, required 1 1", overrun, busy);
        end
        cycles(7);                                      // T+13
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL overrun_done: done got %b, required 1", done);
        end
        cycles(1);                                      // T+14, idle
        n_checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL overrun_sticky: overrun=%b busy=%b, required 1 0", overrun, busy);
        end
        // Simultaneous tick and spawn in IDLE
        spawn_x = 8'd40; spawn_y = 8'd60; spawn_dir = 2'b10; spawn_valid = 1'b1;
        tick = 1'b1;
        #1;
        n_checks++;
        if (spawn_ready !== 1'b0) begin
            n_fail++; $display("FAIL prio_ready: spawn_ready got %b, required 0", spawn_ready);
        end
        @(posedge clk);
        #1;
        tick = 1'b0;
        do_spawn(8'd40, 8'd60, 2'b10, w);
        n_checks++;
        if (w != 13) begin
            n_fail++; $display("FAIL prio_wait: waited %0d cycles, required 13", w);
        end
        e1 = {8'd60, 8'd40, 2'b10, 1'b1};
        n_checks++;
        if (m1 !== e1) begin
            n_fail++; $display("FAIL prio_slot: m1 got %h, required %h", m1, e1);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_spawn_and_move();
        test_bounce();
        test_fill_and_clamp();
        test_kill_during_scan();
        test_overrun_and_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
